// File: rtl/bpm_pkg.sv
// Shared definitions for the BPM measurement pipeline: the sequencer state
// encoding, the default result width and the default rate constants.
package bpm_pkg;

  localparam int DEF_CLK_FREQ_HZ      = 10_000_000;
  localparam int DEF_SAMPLE_RATE_HZ   = 100;
  localparam int DEF_WINDOW_SAMPLES   = 1000;
  localparam int DEF_CALC_TIMEOUT_CYC = 100_000;
  localparam int DEF_BPM_WIDTH        = 8;
  localparam int FIFO_DEPTH           = 1024;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_ACQUIRE = 2'd2,
    S_CALC    = 2'd3
  } bpm_state_t;

endpackage

// File: rtl/bpm_tick_gen.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and wraps; o_tick is
// high while the count sits at DIV-1. i_clr restarts the count at 0.
module bpm_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider count: synchronous clear wins, otherwise wrap at DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/bpm_measure_ctrl.sv
// BPM measurement sequencer: flush FIFO, capture a window of samples at the
// sample rate, run the BPM calculator and publish the result.
// Optional feature macro: BPM_CTRL_TIMEOUT_EN bounds the wait in CALC.
module bpm_measure_ctrl
  import bpm_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = DEF_CLK_FREQ_HZ,
  parameter int SAMPLE_RATE_HZ   = DEF_SAMPLE_RATE_HZ,
  parameter int WINDOW_SAMPLES   = DEF_WINDOW_SAMPLES,
  parameter int CALC_TIMEOUT_CYC = DEF_CALC_TIMEOUT_CYC,
  parameter int BPM_WIDTH        = DEF_BPM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 check_req,
  input  logic                 fifo_full,
  output logic                 fifo_clr,
  output logic                 fifo_wr_en,
  output logic                 calc_start,
  input  logic                 calc_done,
  input  logic [BPM_WIDTH-1:0] calc_bpm,
  output logic [BPM_WIDTH-1:0] bpm_latest,
  output logic                 bpm_ready,
  output logic                 busy,
  output logic                 err_overflow,
  output logic                 err_timeout
);

  localparam int DIV = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int SW  = $clog2(WINDOW_SAMPLES + 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(WINDOW_SAMPLES - 1);

  // Elaboration-time parameter sanity.
  if (DIV < 2 || (DIV * SAMPLE_RATE_HZ) != CLK_FREQ_HZ) begin : g_bad_div
    $error("bpm_measure_ctrl: clock/sample-rate ratio must be an integer >= 2");
  end
  if (WINDOW_SAMPLES < 1 || WINDOW_SAMPLES > FIFO_DEPTH) begin : g_bad_win
    $error("bpm_measure_ctrl: window must fit in the sample FIFO");
  end
  if (CALC_TIMEOUT_CYC < 1) begin : g_bad_to
    $error("bpm_measure_ctrl: calculator timeout must be at least one cycle");
  end

  bpm_state_t           r_state;
  logic [SW-1:0]        r_sample_cnt;
  logic                 r_fifo_clr;
  logic                 r_calc_start;
  logic                 r_bpm_ready;
  logic [BPM_WIDTH-1:0] r_bpm_latest;
  logic                 r_err_overflow;
  logic                 w_tick;

  bpm_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == S_FLUSH),
    .i_en   (r_state == S_ACQUIRE),
    .o_tick (w_tick)
  );

`ifdef BPM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(CALC_TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CALC_TIMEOUT_CYC - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err_timeout;
`endif

  // Sequencer FSM with its sample counter, result latch and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_sample_cnt   <= '0;
      r_fifo_clr     <= 1'b0;
      r_calc_start   <= 1'b0;
      r_bpm_ready    <= 1'b0;
      r_bpm_latest   <= '0;
      r_err_overflow <= 1'b0;
`ifdef BPM_CTRL_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_err_timeout  <= 1'b0;
`endif
    end else begin
      r_fifo_clr   <= 1'b0;
      r_calc_start <= 1'b0;
      r_bpm_ready  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (check_req && en) begin
            r_err_overflow <= 1'b0;
`ifdef BPM_CTRL_TIMEOUT_EN
            r_err_timeout  <= 1'b0;
`endif
            r_fifo_clr     <= 1'b1;
            r_state        <= S_FLUSH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else begin
            r_sample_cnt <= '0;
            r_state      <= S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (fifo_full) begin
              r_err_overflow <= 1'b1;
              r_state        <= S_IDLE;
            end else if (r_sample_cnt == SAMPLE_LAST) begin
              r_calc_start <= 1'b1;
`ifdef BPM_CTRL_TIMEOUT_EN
              r_to_cnt     <= '0;
`endif
              r_state      <= S_CALC;
            end else begin
              r_sample_cnt <= r_sample_cnt + SW'(1);
            end
          end else begin
            r_state <= S_ACQUIRE;
          end
        end
        S_CALC: begin
          if (!en) begin
            r_state <= S_IDLE;
          end else if (calc_done) begin
            r_bpm_latest <= calc_bpm;
            r_bpm_ready  <= 1'b1;
            r_state      <= S_IDLE;
`ifdef BPM_CTRL_TIMEOUT_EN
          end else if (r_to_cnt == TO_LAST) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
`else
          end else begin
            r_state <= S_CALC;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe must see fifo_full and en in the tick cycle itself.
  assign fifo_wr_en   = (r_state == S_ACQUIRE) && w_tick && en && !fifo_full;
  assign fifo_clr     = r_fifo_clr;
  assign calc_start   = r_calc_start;
  assign bpm_ready    = r_bpm_ready;
  assign bpm_latest   = r_bpm_latest;
  assign busy         = (r_state != S_IDLE);
  assign err_overflow = r_err_overflow;
`ifdef BPM_CTRL_TIMEOUT_EN
  assign err_timeout  = r_err_timeout;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_bpm_measure_ctrl.sv
// Directed bench for bpm_measure_ctrl with DIV=10, WINDOW_SAMPLES=8.
// Expected traces are hand-derived per scenario; cycle 0 is the request cycle.
module tb_bpm_measure_ctrl;

  localparam int M_NOM   = 0;
  localparam int M_DROP  = 1;
  localparam int M_ABORT = 2;
  localparam int M_OVF   = 3;
  localparam int M_TMO   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       check_req;
  logic       fifo_full;
  logic       fifo_clr;
  logic       fifo_wr_en;
  logic       calc_start;
  logic       calc_done;
  logic [7:0] calc_bpm;
  logic [7:0] bpm_latest;
  logic       bpm_ready;
  logic       busy;
  logic       err_overflow;
  logic       err_timeout;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_latest = 8'd0;

  bpm_measure_ctrl #(
    .CLK_FREQ_HZ      (1000),
    .SAMPLE_RATE_HZ   (100),
    .WINDOW_SAMPLES   (8),
    .CALC_TIMEOUT_CYC (20),
    .BPM_WIDTH        (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .check_req    (check_req),
    .fifo_full    (fifo_full),
    .fifo_clr     (fifo_clr),
    .fifo_wr_en   (fifo_wr_en),
    .calc_start   (calc_start),
    .calc_done    (calc_done),
    .calc_bpm     (calc_bpm),
    .bpm_latest   (bpm_latest),
    .bpm_ready    (bpm_ready),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs_now();
    return {fifo_clr, fifo_wr_en, calc_start, bpm_ready, busy, err_overflow, err_timeout};
  endfunction

  // Hand-derived expected {clr, wr, start, ready, busy, ovf, tmo} for cycle c.
  function automatic logic [6:0] exp_vec(input int mode, input int c);
    logic clr, wr, st, rdy, bsy, ovf, tmo;
    int   last_wr;
    clr = (c == 1) || (mode == M_OVF && c == 56);
    case (mode)
      M_OVF:   last_wr = 41;
      M_ABORT: last_wr = 21;
      default: last_wr = 81;
    endcase
    wr  = (c >= 11) && (c <= last_wr) && ((c % 10) == 1);
    st  = (c == 82) && (mode == M_NOM || mode == M_DROP || mode == M_TMO);
    rdy = (c == 91) && (mode == M_NOM || mode == M_DROP);
    ovf = (mode == M_OVF) && (c >= 52) && (c <= 55);
    tmo = 1'b0;
    case (mode)
      M_NOM, M_DROP: bsy = (c >= 1) && (c <= 90);
      M_ABORT:       bsy = (c >= 1) && (c <= 30);
      M_OVF:         bsy = ((c >= 1) && (c <= 51)) || (c >= 56);
`ifdef BPM_CTRL_TIMEOUT_EN
      M_TMO: begin
        bsy = (c >= 1) && (c <= 101);
        tmo = (c >= 102);
      end
`else
      M_TMO:         bsy = (c >= 1);
`endif
      default:       bsy = 1'b0;
    endcase
    return {clr, wr, st, rdy, bsy, ovf, tmo};
  endfunction

  // Drive one scenario from cycle 0 through last_c, checking every cycle.
  task automatic run_scen(input int mode, input int last_c, input logic [7:0] bpm);
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      check_req = (c == 0) || (mode == M_DROP && (c == 40 || c == 90)) ||
                  (mode == M_OVF && c == 55);
      fifo_full = (mode == M_OVF) && (c == 51);
      en        = !((mode == M_ABORT) && (c >= 30) && (c <= 35));
      calc_done = ((mode == M_NOM || mode == M_DROP) && c == 90) ||
                  (mode == M_ABORT && c == 50);
      calc_bpm  = (mode == M_ABORT) ? 8'd99 : (calc_done ? bpm : 8'd0);
      #1;
      if (c == 91 && (mode == M_NOM || mode == M_DROP)) exp_latest = bpm;
      check_val($sformatf("m%0d_c%0d_outs", mode, c), 32'(outs_now()), 32'(exp_vec(mode, c)));
      check_val($sformatf("m%0d_c%0d_latest", mode, c), 32'(bpm_latest), 32'(exp_latest));
    end
  endtask

  // Return to IDLE between scenarios with a short enable drop.
  task automatic settle();
    @(negedge clk);
    check_req = 1'b0; fifo_full = 1'b0; calc_done = 1'b0; en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; check_req = 1'b0; fifo_full = 1'b0;
    calc_done = 1'b0; calc_bpm = 8'd0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", 32'(outs_now()), 32'd0);
    check_val("reset_latest", 32'(bpm_latest), 32'd0);
    rst = 1'b0;

    run_scen(M_NOM, 95, 8'd72);   settle();
    run_scen(M_DROP, 95, 8'd80);  settle();
    run_scen(M_ABORT, 100, 8'd0); settle();
    run_scen(M_OVF, 57, 8'd0);    settle();

    // Reset mid-ACQUIRE: run the nominal start through cycle 39, hit reset.
    run_scen(M_NOM, 39, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_latest = 8'd0;
    check_val("rst_mid_outs", 32'(outs_now()), 32'd0);
    check_val("rst_mid_latest", 32'(bpm_latest), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_scen(M_NOM, 95, 8'd65);   settle();

    run_scen(M_TMO, 110, 8'd0);   settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
